// File: rtl/i2c_master_seq_if.sv
// Handshake and datapath-control bundle between the I2C master sequencer and the byte datapath/FIFOs.
// Adds scl_i when I2C_CLOCK_STRETCH_EN is defined.
interface i2c_master_seq_if #(
  parameter int unsigned CNT_W = 3,
  parameter int unsigned LEN_W = 8
);
  logic             start_i;
  logic             rw_i;
  logic [LEN_W-1:0] num_bytes_i;
  logic             tx_fifo_empty_i;
  logic             rx_fifo_full_i;
  logic             i2c_sda_i;
`ifdef I2C_CLOCK_STRETCH_EN
  logic             scl_i;
`endif
  logic             sda_low_en_o;
  logic             write_addr_en_o;
  logic             write_data_en_o;
  logic             receive_data_en_o;
  logic [CNT_W-1:0] count_bit_o;
  logic             scl_en_o;
  logic             tx_fifo_rd_en_o;
  logic             rx_fifo_wr_en_o;
  logic             ack_error_o;
  logic             busy_o;

  // Sequencer side
  modport master (
`ifdef I2C_CLOCK_STRETCH_EN
    input  scl_i,
`endif
    input  start_i, rw_i, num_bytes_i, tx_fifo_empty_i, rx_fifo_full_i, i2c_sda_i,
    output sda_low_en_o, write_addr_en_o, write_data_en_o, receive_data_en_o,
    output count_bit_o, scl_en_o, tx_fifo_rd_en_o, rx_fifo_wr_en_o, ack_error_o, busy_o
  );

  // Datapath / controller side
  modport slave (
`ifdef I2C_CLOCK_STRETCH_EN
    output scl_i,
`endif
    output start_i, rw_i, num_bytes_i, tx_fifo_empty_i, rx_fifo_full_i, i2c_sda_i,
    input  sda_low_en_o, write_addr_en_o, write_data_en_o, receive_data_en_o,
    input  count_bit_o, scl_en_o, tx_fifo_rd_en_o, rx_fifo_wr_en_o, ack_error_o, busy_o
  );
endinterface

// File: rtl/i2c_master_seq_fsm.sv
// I2C master transaction sequencer: START, address+R/W, ACK, N data bytes with ACK/NACK, STOP.
// Optional slave clock stretching in the ACK states via I2C_CLOCK_STRETCH_EN.
module i2c_master_seq_fsm #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned CNT_W     = 3,
  parameter int unsigned LEN_W     = 8
) (
  input logic              i2c_core_clk_i,
  input logic              reset_ni,
  i2c_master_seq_if.master bus
);

  localparam logic [CNT_W-1:0] BitFirst = CNT_W'(DATA_SIZE - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [LEN_W-1:0] remain_q;
  logic             rw_q;
  logic             ack_error_q;
  logic             sda_drive_q, addr_en_q, data_en_q, rx_en_q, scl_en_q, busy_q;
  logic             ack_go, bit_last, more_rd;

  // ACK states advance only once SCL is released by the slave
`ifdef I2C_CLOCK_STRETCH_EN
  assign ack_go = bus.scl_i;
`else
  assign ack_go = 1'b1;
`endif

  assign bit_last = (count_q == '0);
  assign more_rd  = (remain_q > LEN_W'(1)) && !bus.rx_fifo_full_i;

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (bus.start_i) state_d = START;
      START:    state_d = ADDR;
      ADDR:     if (bit_last) state_d = ADDR_ACK;
      ADDR_ACK: if (ack_go) begin
        if (bus.i2c_sda_i)  state_d = STOP;
        else if (!rw_q)     state_d = bus.tx_fifo_empty_i ? STOP : WR_DATA;
        else                state_d = (remain_q == '0) ? STOP : RD_DATA;
      end
      WR_DATA:  if (bit_last) state_d = WR_ACK;
      WR_ACK:   if (ack_go) state_d = (bus.i2c_sda_i || bus.tx_fifo_empty_i) ? STOP : WR_DATA;
      RD_DATA:  if (bit_last) state_d = RD_ACK;
      RD_ACK:   if (ack_go) state_d = more_rd ? RD_DATA : STOP;
      STOP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State, counters and registered Moore enables (decoded from the next state)
  always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      count_q     <= BitFirst;
      remain_q    <= '0;
      rw_q        <= 1'b0;
      ack_error_q <= 1'b0;
      sda_drive_q <= 1'b0;
      addr_en_q   <= 1'b0;
      data_en_q   <= 1'b0;
      rx_en_q     <= 1'b0;
      scl_en_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sda_drive_q <= (state_d == START) || (state_d == STOP);
      addr_en_q   <= (state_d == ADDR);
      data_en_q   <= (state_d == WR_DATA);
      rx_en_q     <= (state_d == RD_DATA);
      scl_en_q    <= !(state_d inside {IDLE, START, STOP});
      busy_q      <= (state_d != IDLE);

      if (state_q inside {ADDR, WR_DATA, RD_DATA}) begin
        count_q <= bit_last ? BitFirst : count_q - CNT_W'(1);
      end

      if (state_q == IDLE && bus.start_i) begin
        rw_q        <= bus.rw_i;
        remain_q    <= bus.num_bytes_i;
        ack_error_q <= 1'b0;
      end

      if (ack_go) begin
        if ((state_q == ADDR_ACK || state_q == WR_ACK) && bus.i2c_sda_i) ack_error_q <= 1'b1;
        if (state_q == RD_ACK) begin
          if (bus.rx_fifo_full_i) ack_error_q <= 1'b1;
          remain_q <= remain_q - LEN_W'(1);
        end
      end
    end
  end

  // ACK-cycle strobes depend on the line/FIFO status sampled in that same cycle
  assign bus.sda_low_en_o      = sda_drive_q || (state_q == RD_ACK && more_rd);
  assign bus.tx_fifo_rd_en_o   = (state_q == WR_ACK) && ack_go && !bus.i2c_sda_i;
  assign bus.rx_fifo_wr_en_o   = (state_q == RD_ACK) && ack_go && !bus.rx_fifo_full_i;
  assign bus.write_addr_en_o   = addr_en_q;
  assign bus.write_data_en_o   = data_en_q;
  assign bus.receive_data_en_o = rx_en_q;
  assign bus.count_bit_o       = count_q;
  assign bus.scl_en_o          = scl_en_q;
  assign bus.ack_error_o       = ack_error_q;
  assign bus.busy_o            = busy_q;

endmodule

// File: tb/tb_i2c_master_seq_fsm.sv
// Directed self-checking bench for i2c_master_seq_fsm: write, read, NACK, RX-full, reset and restart cases.
module tb_i2c_master_seq_fsm;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned LEN_W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_master_seq_if #(.CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

  i2c_master_seq_fsm #(.DATA_SIZE(8), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .i2c_core_clk_i(clk),
    .reset_ni      (rst_n),
    .bus           (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {sda_low, addr, data, rx, scl_en, tx_pop, rx_push, busy}
  function automatic logic [7:0] outs();
    return {bus.sda_low_en_o, bus.write_addr_en_o, bus.write_data_en_o, bus.receive_data_en_o,
            bus.scl_en_o, bus.tx_fifo_rd_en_o, bus.rx_fifo_wr_en_o, bus.busy_o};
  endfunction

  // k counts cycles after start is captured: k=1 START, 2..9 ADDR, 10 ADDR_ACK,
  // byte j data at 11+9j..18+9j, its ACK at 19+9j (without stretching).
  task automatic run_txn(input string tag, input logic rw, input logic [7:0] nb, input int ntx,
                         input int nack_k, input int full_k, input int stretch_k, input int restart_k,
                         input int exp_busy, input int exp_pops, input int exp_pushes,
                         input logic exp_ack, input logic [7:0] exp_mack, input logic exp_data);
    int busy_cnt = 0, pops = 0, pushes = 0, sda_viol = 0;
    logic data_seen = 1'b0;
    logic done = 1'b0;
    logic [7:0] mack = 8'h01;
    int nen;
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.rw_i = rw; bus.num_bytes_i = nb;
    bus.tx_fifo_empty_i = (ntx == 0); bus.i2c_sda_i = 1'b0; bus.rx_fifo_full_i = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      @(posedge clk); #1;
      bus.start_i         = (k == restart_k);
      bus.i2c_sda_i       = (k == nack_k);
      bus.rx_fifo_full_i  = (k == full_k);
      bus.tx_fifo_empty_i = (pops + 1 >= ntx);
`ifdef I2C_CLOCK_STRETCH_EN
      bus.scl_i = !(stretch_k > 0 && k >= stretch_k && k < stretch_k + 5);
`endif
      #1;
      if (!bus.busy_o) begin
        done = 1'b1;
        break;
      end
      busy_cnt++;
      if (k == 1) begin
        check({tag, " start outs"}, 32'(outs()), 32'h81);
        check({tag, " ack clr"}, 32'(bus.ack_error_o), 32'h0);
      end
      if (k >= 2 && k <= 9)
        check({tag, " addr bit"}, 32'({bus.write_addr_en_o, bus.count_bit_o}), 32'({1'b1, 3'(9 - k)}));
      nen = int'(bus.sda_low_en_o) + int'(bus.write_addr_en_o) + int'(bus.write_data_en_o)
          + int'(bus.receive_data_en_o);
      if (nen > 1) sda_viol++;
      if (bus.tx_fifo_rd_en_o) pops++;
      if (bus.rx_fifo_wr_en_o) pushes++;
      if (bus.write_data_en_o || bus.receive_data_en_o) data_seen = 1'b1;
      if (rw && k >= 19 && (k - 19) % 9 == 0) mack = {mack[6:0], bus.sda_low_en_o};
    end
    check({tag, " finished"}, 32'(done), 32'h1);
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check({tag, " tx pops"}, 32'(pops), 32'(exp_pops));
    check({tag, " rx pushes"}, 32'(pushes), 32'(exp_pushes));
    check({tag, " ack_error"}, 32'(bus.ack_error_o), 32'(exp_ack));
    check({tag, " master ack"}, 32'(mack), 32'(exp_mack));
    check({tag, " data seen"}, 32'(data_seen), 32'(exp_data));
    check({tag, " sda onehot"}, 32'(sda_viol), 32'h0);
    check({tag, " idle outs"}, 32'(outs()), 32'h0);
  endtask

  initial begin
    bus.start_i = 1'b0; bus.rw_i = 1'b0; bus.num_bytes_i = '0;
    bus.tx_fifo_empty_i = 1'b1; bus.rx_fifo_full_i = 1'b0; bus.i2c_sda_i = 1'b0;
`ifdef I2C_CLOCK_STRETCH_EN
    bus.scl_i = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset outs", 32'(outs()), 32'h0);
    check("reset count", 32'(bus.count_bit_o), 32'h7);
    check("reset ack", 32'(bus.ack_error_o), 32'h0);
    rst_n = 1'b1;

    //      tag            rw  nb    ntx nack full str rst  busy pops push ack mack  data
    run_txn("wr2",        1'b0, 8'd0, 2, -1, -1, -1, -1,   29,  2,   0, 1'b0, 8'h01, 1'b1);
    run_txn("rd3",        1'b1, 8'd3, 0, -1, -1, -1, -1,   38,  0,   3, 1'b0, 8'h0E, 1'b1);
    run_txn("rd1",        1'b1, 8'd1, 0, -1, -1, -1, -1,   20,  0,   1, 1'b0, 8'h02, 1'b1);
    run_txn("rd0",        1'b1, 8'd0, 0, -1, -1, -1, -1,   11,  0,   0, 1'b0, 8'h01, 1'b0);
    run_txn("wr_empty",   1'b0, 8'd0, 0, -1, -1, -1, -1,   11,  0,   0, 1'b0, 8'h01, 1'b0);
    run_txn("addr_nack",  1'b0, 8'd0, 2, 10, -1, -1, -1,   11,  0,   0, 1'b1, 8'h01, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("ack sticky", 32'(bus.ack_error_o), 32'h1);
    run_txn("rd_full",    1'b1, 8'd3, 0, -1, 19, -1, -1,   20,  0,   0, 1'b1, 8'h02, 1'b1);
    run_txn("wr_nack",    1'b0, 8'd0, 2, 19, -1, -1, -1,   20,  0,   0, 1'b1, 8'h01, 1'b1);
    run_txn("wr_restart", 1'b0, 8'd0, 2, -1, -1, -1, 5,    29,  2,   0, 1'b0, 8'h01, 1'b1);
`ifdef I2C_CLOCK_STRETCH_EN
    run_txn("wr_stretch", 1'b0, 8'd0, 1, -1, -1, 19, -1,   25,  1,   0, 1'b0, 8'h01, 1'b1);
`endif

    // Asynchronous reset in the middle of the first data byte
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.rw_i = 1'b0; bus.tx_fifo_empty_i = 1'b0; bus.i2c_sda_i = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      bus.start_i = 1'b0;
    end
    #1;
    check("pre-reset wr bit", 32'({bus.write_data_en_o, bus.count_bit_o}), 32'({1'b1, 3'd4}));
    rst_n = 1'b0;
    #1;
    check("mid reset outs", 32'(outs()), 32'h0);
    check("mid reset count", 32'(bus.count_bit_o), 32'h7);
    check("mid reset ack", 32'(bus.ack_error_o), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_txn("post_reset", 1'b0, 8'd0, 2, -1, -1, -1, -1,   29,  2,   0, 1'b0, 8'h01, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
